// File: rtl/register_file_if.sv
// Register-file access bus: one write port and two independent read ports.
// master drives the write enable/index/data and both read indexes and
// receives both read data words; slave is the register file side.
interface register_file_if #(
  parameter int unsigned N_BITS = 32
);
  logic              Reg_Write_i;
  logic [4:0]        Write_Register_i;
  logic [N_BITS-1:0] Write_Data_i;
  logic [4:0]        Read_Register_1_i;
  logic [4:0]        Read_Register_2_i;
  logic [N_BITS-1:0] Read_Data_1_o;
  logic [N_BITS-1:0] Read_Data_2_o;

  modport master (
    output Reg_Write_i,
    output Write_Register_i,
    output Write_Data_i,
    output Read_Register_1_i,
    output Read_Register_2_i,
    input  Read_Data_1_o,
    input  Read_Data_2_o
  );

  modport slave (
    input  Reg_Write_i,
    input  Write_Register_i,
    input  Write_Data_i,
    input  Read_Register_1_i,
    input  Read_Register_2_i,
    output Read_Data_1_o,
    output Read_Data_2_o
  );
endinterface

// File: rtl/register_file.sv
// 32 x N_BITS integer register file, x0 hardwired to zero.
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - synchronous active-high reset; x2 <- SP_INIT, x3 <- GP_INIT, others 0
//   rf    - register_file_if.slave: write port (Reg_Write_i, Write_Register_i,
//           Write_Data_i) and two combinational read ports
//           (Read_Register_{1,2}_i -> Read_Data_{1,2}_o)
// BYPASS=1 forwards the in-flight write data to a read port addressing rd.
module register_file #(
  parameter int unsigned       N_BITS  = 32,
  parameter logic [N_BITS-1:0] SP_INIT = N_BITS'(32'h7FFF_EFFC),
  parameter logic [N_BITS-1:0] GP_INIT = N_BITS'(32'h1000_8000),
  parameter bit                BYPASS  = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  register_file_if.slave rf
);

  localparam int unsigned N_REGS = 32;

  // x0 has no storage, so the array starts at index 1.
  logic [N_BITS-1:0] regs_q [1:N_REGS-1];
  logic [N_BITS-1:0] regs_d [1:N_REGS-1];

  logic              wr_en_c;
  logic [N_BITS-1:0] rd1_arr_c;
  logic [N_BITS-1:0] rd2_arr_c;

  // A write is effective only when enabled and not targeting x0.
  assign wr_en_c = rf.Reg_Write_i && (rf.Write_Register_i != 5'd0);

  // Next-state: copy current contents, then overlay the single write.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < N_REGS; i++) begin
      if (wr_en_c && (rf.Write_Register_i == 5'(i))) begin
        regs_d[i] = rf.Write_Data_i;
      end
    end
  end

  // State register; reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < N_REGS; i++) begin
        if (i == 2) begin
          regs_q[i] <= SP_INIT;
        end else if (i == 3) begin
          regs_q[i] <= GP_INIT;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Full 5-bit decode of each read index; index 0 matches nothing and reads 0.
  always_comb begin
    rd1_arr_c = '0;
    rd2_arr_c = '0;
    for (int i = 1; i < N_REGS; i++) begin
      if (rf.Read_Register_1_i == 5'(i)) begin
        rd1_arr_c = regs_q[i];
      end
      if (rf.Read_Register_2_i == 5'(i)) begin
        rd2_arr_c = regs_q[i];
      end
    end
  end

  // Optional same-cycle forwarding; wr_en_c already excludes x0.
  always_comb begin
    rf.Read_Data_1_o = rd1_arr_c;
    rf.Read_Data_2_o = rd2_arr_c;
    if (BYPASS && wr_en_c) begin
      if (rf.Read_Register_1_i == rf.Write_Register_i) begin
        rf.Read_Data_1_o = rf.Write_Data_i;
      end
      if (rf.Read_Register_2_i == rf.Write_Register_i) begin
        rf.Read_Data_2_o = rf.Write_Data_i;
      end
    end
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter N_BITS, 32, data width of every register and data port.
REQ-002 Parameter SP_INIT, 32'h7FFF_EFFC, reset value of x2 (sp).
REQ-003 Parameter GP_INIT, 32'h1000_8000, reset value of x3 (gp).
REQ-004 Parameter BYPASS, 0, when 1 enables write-to-read forwarding in the same cycle.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 Reg_Write_i  input  1  write enable for the write port.
REQ-008 Write_Register_i  input  5  destination register index rd.
REQ-009 Write_Data_i  input  N_BITS  data to write into rd.
REQ-010 Read_Register_1_i  input  5  source index rs1.
REQ-011 Read_Register_2_i  input  5  source index rs2.
REQ-012 Read_Data_1_o  output  N_BITS  contents of rs1; feeds ALU operand A_i.
REQ-013 Read_Data_2_o  output  N_BITS  contents of rs2; feeds ALU operand B_i / store data.

Function
REQ-014 The block SHALL hold 32 registers x0..x31 of N_BITS each; x0 SHALL always read 0.
REQ-015 Reads SHALL be combinational: outputs change in the same cycle the read index or the addressed contents change, with zero clock latency.
REQ-016 On a rising clk with reset=0, Reg_Write_i=1 and Write_Register_i!=0, register[Write_Register_i] SHALL take Write_Data_i.
REQ-017 Writes with Write_Register_i=0 SHALL be discarded; x0 has no storage and no side effects.
REQ-018 Reg_Write_i=0 SHALL leave all registers unchanged, regardless of the write index or data.
REQ-019 One write per cycle maximum; both read ports SHALL be independent and MAY address the same register, including each other and rd.
REQ-020 BYPASS=0: a read of rd while it is being written SHALL return the old value until the edge, then the new value.
REQ-021 BYPASS=1: when Reg_Write_i=1 and Write_Register_i!=0 equals a read index, that port SHALL output Write_Data_i combinationally; index 0 SHALL never bypass.
REQ-022 Each port index SHALL be decoded fully (5 bits); no aliasing between registers.
REQ-023 Written data SHALL be stored unmodified (no sign or zero extension; the width is exactly N_BITS).

Reset
REQ-024 On a rising clk with reset=1, all registers SHALL become 0 except x2=SP_INIT and x3=GP_INIT.
REQ-025 Reset SHALL take priority over a simultaneous write; the write in that cycle is lost.
REQ-026 While reset is asserted, read ports SHALL continue to reflect current contents combinationally (post-reset values after the first reset edge).
REQ-027 Reset asserted mid-program SHALL restore REQ-024 values in one edge; deassertion requires no extra settling cycles.

Verification
REQ-028 Reset 1 cycle, read rs1=2, rs2=3 -> 32'h7FFF_EFFC, 32'h1000_8000; rs1=5 -> 0.
REQ-029 Write x5=32'hDEAD_BEEF, next cycle rs1=rs2=5 -> both 32'hDEAD_BEEF; x6 read -> 0.
REQ-030 Write x0=32'hFFFF_FFFF with Reg_Write_i=1 -> rs1=0 reads 0; no other register changes.
REQ-031 Reg_Write_i=0, rd=7, data=32'h1234 -> x7 stays 0.
REQ-032 Same cycle write x9=32'hA5A5_A5A5 with rs1=9: BYPASS=0 -> old 0 before the edge, A5A5_A5A5 after; BYPASS=1 -> A5A5_A5A5 before the edge.
REQ-033 reset=1 together with write x2=32'h1 -> x2 reads 32'h7FFF_EFFC after the edge; write all 31 registers with their index, then read back all -> matches.
